// File: rtl/relu_stream_ctrl_if.sv
// rtl/relu_stream_ctrl_if.sv - input/output beat stream bundle for relu_stream_ctrl
interface relu_stream_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int CH_W       = 5,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic                        out_last;
    logic [CH_W-1:0]             out_ch;
    logic [ROW_W-1:0]            out_row;
    logic [COL_W-1:0]            out_col;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch, out_row, out_col
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch, out_row, out_col
    );
endinterface

// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - per-frame ReLU beat sequencer with one output register stage
// Optional RELU_CLIP_EN clamps each lane to [0, CLIP_VALUE].
module relu_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 32,
    parameter int HEIGHT     = 28,
    parameter int WIDTH      = 28,
    parameter int LANES      = 4,
    parameter int CLIP_VALUE = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    relu_stream_ctrl_if.slave s
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BUS_W = LANES * DATA_WIDTH;

    generate
        if (WIDTH % LANES != 0) begin : g_bad_lanes
            $error("relu_stream_ctrl: WIDTH must be a multiple of LANES");
        end
        if (CLIP_VALUE < 0) begin : g_bad_clip
            $error("relu_stream_ctrl: CLIP_VALUE must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [BUS_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;
    logic [COL_W-1:0]   out_col_q, out_col_d;

    logic               accept;
    logic               out_fire;
    logic               col_wrap;
    logic               row_wrap;
    logic               ch_wrap;
    logic               last_in;
    logic [BUS_W-1:0]   act_data;

    function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] p);
        logic [DATA_WIDTH-1:0] r;
        r = p[DATA_WIDTH-1] ? '0 : p;
`ifdef RELU_CLIP_EN
        if (!p[DATA_WIDTH-1] && (p > DATA_WIDTH'(CLIP_VALUE)))
            r = DATA_WIDTH'(CLIP_VALUE);
`else
`endif
        return r;
    endfunction

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign s.in_ready = (state_q == RUN) && (!out_valid_q || s.out_ready);
    assign accept     = s.in_valid && s.in_ready;
    assign out_fire   = out_valid_q && s.out_ready;

    assign col_wrap = (col_q == COL_W'(WIDTH - LANES));
    assign row_wrap = (row_q == ROW_W'(HEIGHT - 1));
    assign ch_wrap  = (ch_q == CH_W'(CHANNELS - 1));
    assign last_in  = col_wrap && row_wrap && ch_wrap;

    always_comb begin
        act_data = '0;
        for (int i = 0; i < LANES; i++)
            act_data[i*DATA_WIDTH +: DATA_WIDTH] = activate(s.in_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ch_d        = ch_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    ch_d    = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept && last_in)
                    state_d = FLUSH;
            end
            FLUSH: begin
                // only the final beat can be left in the output register here
                if (out_fire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = last_in;
            out_data_d  = act_data;
            out_ch_d    = ch_q;
            out_row_d   = row_q;
            out_col_d   = col_q;
            if (col_wrap) begin
                col_d = '0;
                if (row_wrap) begin
                    row_d = '0;
                    ch_d  = ch_wrap ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + COL_W'(LANES);
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.out_data  = out_data_q;
    assign s.out_ch    = out_ch_q;
    assign s.out_row   = out_row_q;
    assign s.out_col   = out_col_q;
endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - scoreboard bench for relu_stream_ctrl on a 2x2x8 frame
module tb_relu_stream_ctrl;
    localparam int DW       = 8;
    localparam int LANES    = 4;
    localparam int CHANNELS = 2;
    localparam int HEIGHT   = 2;
    localparam int WIDTH    = 8;
    localparam int CH_W     = 1;
    localparam int ROW_W    = 1;
    localparam int COL_W    = 3;
    localparam int BPR      = WIDTH / LANES;
    localparam int BEATS    = CHANNELS * HEIGHT * BPR;

    typedef struct packed {
        logic [31:0]      data;
        logic             last;
        logic [CH_W-1:0]  ch;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    relu_stream_ctrl_if #(.DATA_WIDTH(DW), .LANES(LANES), .CH_W(CH_W),
                          .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    relu_stream_ctrl #(.DATA_WIDTH(DW), .CHANNELS(CHANNELS), .HEIGHT(HEIGHT),
                       .WIDTH(WIDTH), .LANES(LANES), .CLIP_VALUE(6)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .s(bus)
    );

    // lane 0 is the low byte: first vector is lanes {0x80,0xFF,0x00,0x7F}
    logic [31:0] vin [BEATS] = '{32'h7F00FF80, 32'h05060701, 32'h81FE403F, 32'h00000000,
                                 32'h10F020E0, 32'h7E8002FD, 32'hC0330109, 32'h0607FF12};
`ifdef RELU_CLIP_EN
    logic [31:0] vexp [BEATS] = '{32'h06000000, 32'h05060601, 32'h00000606, 32'h00000000,
                                  32'h06000600, 32'h06000200, 32'h00060106, 32'h06060006};
`else
    logic [31:0] vexp [BEATS] = '{32'h7F000000, 32'h05060701, 32'h0000403F, 32'h00000000,
                                  32'h10002000, 32'h7E000200, 32'h00330109, 32'h06070012};
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int start_req = 0;
    int start_ack = 0;
    int rmode = 0;
    int vmode = 0;
    bit spam_start = 1'b0;
    int frame_cyc = 0;
    int mon_beat = 0;
    int done_cnt = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // input driver: start pulses, out_ready pattern, in_valid/in_data
    initial begin
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (start_ack != start_req) begin
                start = 1'b1;
                start_ack++;
                frame_cyc = 0;
            end else begin
                start = spam_start && busy;
            end
            frame_cyc++;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = !(frame_cyc >= 4 && frame_cyc < 9);
            endcase
            if (!rst && busy && mon_beat < BEATS && (vmode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vin[mon_beat];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    end

    // monitor: pushes on input handshake, pops and compares on output handshake
    bit          exp_done = 1'b0;
    bit          acc_prev = 1'b0;
    bit          hold_pending = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst) begin
            sb.delete();
            exp_done     = 1'b0;
            acc_prev     = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (exp_done || done) begin
                chk("done_pulse", 32'(done), 32'(exp_done));
                if (done) begin
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                    done_cnt++;
                end
                exp_done = 1'b0;
            end
            if (acc_prev)
                chk("latency_1", 32'(bus.out_valid), 32'd1);
            if (hold_pending) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", bus.out_data, held_data);
                chk("hold_last", 32'(bus.out_last), 32'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    got = '{bus.out_data, bus.out_last, bus.out_ch, bus.out_row, bus.out_col};
                    chk("out_data", got.data, e.data);
                    chk("out_last", 32'(got.last), 32'(e.last));
                    chk("out_ch", 32'(got.ch), 32'(e.ch));
                    chk("out_row", 32'(got.row), 32'(e.row));
                    chk("out_col", 32'(got.col), 32'(e.col));
                    if (e.last)
                        exp_done = 1'b1;
                end
            end
            if (bus.out_valid && !bus.out_ready)
                chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
            hold_pending = bus.out_valid && !bus.out_ready;
            held_data    = bus.out_data;
            held_last    = bus.out_last;
            if (start && !busy)
                mon_beat = 0;
            acc_prev = bus.in_valid && bus.in_ready;
            if (acc_prev) begin
                e.data = vexp[mon_beat];
                e.last = (mon_beat == BEATS - 1);
                e.ch   = CH_W'(mon_beat / (BPR * HEIGHT));
                e.row  = ROW_W'((mon_beat / BPR) % HEIGHT);
                e.col  = COL_W'((mon_beat % BPR) * LANES);
                sb.push_back(e);
                mon_beat++;
            end
        end
    end

    task automatic run_frame(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        start_req++;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done_cnt), 32'(d0 + 1));
        @(posedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_beats"}, 32'(mon_beat), 32'(BEATS));
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_out_row", 32'(bus.out_row), 32'd0);
        chk("rst_out_col", 32'(bus.out_col), 32'd0);
        rst = 1'b0;

        rmode = 0; vmode = 0;
        run_frame("full_rate");

        rmode = 2; vmode = 0;
        run_frame("stall");

        rmode = 1; vmode = 1;
        run_frame("random_a");
        run_frame("random_b");

        rmode = 0; vmode = 0;
        start_req++;
        n = 0;
        while (mon_beat < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("rst_mid_reached", 32'(mon_beat >= 3), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", bus.out_data, 32'd0);
        chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
        chk("idle_after_rst", 32'(busy), 32'd0);
        run_frame("after_rst");

        spam_start = 1'b1;
        d0 = done_cnt;
        run_frame("start_spam");
        spam_start = 1'b0;
        repeat (6) @(posedge clk);
        chk("single_done_spam", 32'(done_cnt), 32'(d0 + 1));
        chk("idle_after_spam", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/relu_stream_ctrl.md
Name: relu_stream_ctrl

Overview:
Sequences ReLU activation over one feature map as a stream of LANES-pixel beats instead of a flat fully-parallel bus. Sits between a conv/pool output stream and the next layer's input buffer. Counts channel/row/column position, applies per-lane ReLU through a one-stage registered pipeline with valid/ready backpressure, and marks frame boundaries. A start pulse arms one frame; done pulses when the final beat leaves.

Parameters:
DATA_WIDTH, 8, signed two's-complement pixel width
CHANNELS, 32, channels per frame
HEIGHT, 28, rows per channel
WIDTH, 28, columns per row
LANES, 4, pixels per beat; WIDTH must be a multiple of LANES (elaboration-time check, $error if not)
CLIP_VALUE, 6, saturation ceiling used only when RELU_CLIP_EN is defined

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; arms a frame when in IDLE, ignored otherwise
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last output beat handshakes
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat
in_data  input  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  LANES*DATA_WIDTH  activated lanes, same packing
out_last  output  1  high on final beat of frame
out_ch  output  $clog2(CHANNELS)  channel index of current output beat
out_row  output  $clog2(HEIGHT)  row index of current output beat
out_col  output  $clog2(WIDTH)  column of lane 0 of current output beat

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0, out_ch/out_row/out_col=0, all counters 0.
- FSM states: IDLE, RUN, FLUSH.
  IDLE: in_ready=0. start -> RUN, busy=1, counters cleared.
  RUN: accept beats; on acceptance of final input beat (ch=CHANNELS-1, row=HEIGHT-1, col=WIDTH-LANES) -> FLUSH.
  FLUSH: in_ready=0; when output register empties (final beat handshakes) -> IDLE, done=1 for exactly one cycle, busy=0 same edge.
- Handshake: input accepted when in_valid && in_ready. In RUN, in_ready = !out_valid || out_ready (single output register, full throughput, no combinational path from in_valid to in_ready). out_data/out_valid/out_last must hold stable while out_valid && !out_ready.
- Latency: accepted beat appears on out_data exactly 1 cycle later.
- Arithmetic: per lane, pixel interpreted signed; pixel<0 -> 0, else pixel unchanged. Most-negative value (0x80 at 8 bits) -> 0. Zero passes as zero.
- Position counters advance on input acceptance: col += LANES; at WIDTH-LANES wraps to 0 and row increments; row wraps at HEIGHT-1 and ch increments; out_ch/out_row/out_col registered alongside the data beat.
- out_last = 1 only with the final beat; cleared when it handshakes.
- start during RUN/FLUSH: ignored, no counter effect.
- in_valid while IDLE/FLUSH: not accepted, no side effect.
- rst mid-frame: immediate abandonment, all outputs to reset values, no done pulse.
- start and final handshake same cycle in FLUSH: start ignored; new frame requires start in IDLE.

Optional Feature:
RELU_CLIP_EN: when defined, per-lane function becomes clamp to [0, CLIP_VALUE] (ReLU6-style); values > CLIP_VALUE output CLIP_VALUE. When undefined, plain ReLU, no upper bound, CLIP_VALUE unused. Latency, handshake and counters identical either way.

Test Plan:
- Reset then start, DATA_WIDTH=8, LANES=4, WIDTH=8, HEIGHT=2, CHANNELS=2, in_valid always, out_ready always -> 8 beats out, 1-cycle latency, out_last on 8th beat only, done one cycle after its handshake, busy low thereafter.
- Beat lanes {0x80, 0xFF, 0x00, 0x7F} -> out lanes {0x00, 0x00, 0x00, 0x7F}; with RELU_CLIP_EN, CLIP_VALUE=6: {0x00,0x00,0x00,0x06}; lane value 0x05 -> 0x05.
- out_ready held low 5 cycles mid-frame -> out_data/out_valid stable, in_ready low, no beat lost or duplicated; indices resume in order.
- Random in_valid/out_ready toggling over a 2x2x8 frame -> out_ch/out_row/out_col sequence (0,0,0),(0,0,4),(0,1,0)... exactly once each; data matches golden model.
- Assert rst on beat 3 of 8 -> outputs zero immediately, no done; subsequent start runs a full clean frame.
- start pulses during RUN and in the cycle of the final handshake -> ignored; exactly one done per accepted start.
